// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: operand/result widths and FSM state type.
package adder_arbiter_pkg;

  localparam int unsigned OPW  = 6;
  localparam int unsigned RESW = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Combinational 6-bit Kogge-Stone prefix adder with bit-level ports and carry-out.
module adder (
  input  logic x0, x1, x2, x3, x4, x5,
  input  logic y0, y1, y2, y3, y4, y5,
  output logic s0, s1, s2, s3, s4, s5,
  output logic ov
);

  logic [5:0] w_x, w_y;
  logic [5:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3;
  logic [5:0] w_s;

  assign w_x  = {x5, x4, x3, x2, x1, x0};
  assign w_y  = {y5, y4, y3, y2, y1, y0};
  assign w_g0 = w_x & w_y;
  assign w_p0 = w_x ^ w_y;

  // Shifted operands zero-fill low bits; those positions are already complete groups.
  assign w_g1 = w_g0 | (w_p0 & (w_g0 << 1));
  assign w_p1 = w_p0 & (w_p0 << 1);
  assign w_g2 = w_g1 | (w_p1 & (w_g1 << 2));
  assign w_p2 = w_p1 & (w_p1 << 2);
  assign w_g3 = w_g2 | (w_p2 & (w_g2 << 4));

  assign w_s = w_p0 ^ {w_g3[4:0], 1'b0};

  assign {s5, s4, s3, s2, s1, s0} = w_s;
  assign ov = w_g3[5];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between two requesters with valid/ready handshakes.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_x,
  input  logic [OPW-1:0]   req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_x,
  input  logic [OPW-1:0]   req1_y,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [RESW-1:0]  rsp_s,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_t           r_state, w_next;
  logic             r_last, r_id;
  logic [OPW-1:0]   r_x, r_y;
  logic [RESW-1:0]  r_res;
  logic [CNT_W-1:0] r_cnt;

  logic             w_grant0, w_grant1, w_acc0, w_acc1, w_done;
  logic [RESW-1:0]  w_sum;

  adder u_adder (
    .x0(r_x[0]), .x1(r_x[1]), .x2(r_x[2]), .x3(r_x[3]), .x4(r_x[4]), .x5(r_x[5]),
    .y0(r_y[0]), .y1(r_y[1]), .y2(r_y[2]), .y3(r_y[3]), .y4(r_y[4]), .y5(r_y[5]),
    .s0(w_sum[0]), .s1(w_sum[1]), .s2(w_sum[2]), .s3(w_sum[3]), .s4(w_sum[4]), .s5(w_sum[5]),
    .ov(w_sum[6])
  );

  always_comb begin
    // On a tie the requester that was not served last wins; r_last=1 favours requester 0.
    w_grant0 = req0_valid && (!req1_valid || r_last);
    w_grant1 = req1_valid && (!req0_valid || !r_last);
    w_acc0   = !rst && (r_state == ST_IDLE) && w_grant0;
    w_acc1   = !rst && (r_state == ST_IDLE) && w_grant1;
    w_done   = (r_state == ST_RESP) && (r_id ? rsp1_ready : rsp0_ready);

    req0_ready = w_acc0;
    req1_ready = w_acc1;
    rsp0_valid = (r_state == ST_RESP) && !r_id;
    rsp1_valid = (r_state == ST_RESP) && r_id;
    rsp_s      = r_res;
    busy       = (r_state != ST_IDLE);
    ops_done   = r_cnt;

    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_acc0 || w_acc1) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (w_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc0 || w_acc1) begin
        r_x  <= w_acc0 ? req0_x : req1_x;
        r_y  <= w_acc0 ? req0_y : req1_y;
        r_id <= w_acc1;
      end
      if (r_state == ST_EXEC) r_res <= w_sum;
      if (w_done) begin
        r_last <= r_id;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (counter width reduced to 4 to reach wrap).
module tb_adder_arbiter;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0] req0_x, req0_y, req1_x, req1_y;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [6:0] rsp_s;
  logic       busy;
  logic [3:0] ops_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  exp_cnt = '0;

  adder_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready", {req1_ready, req0_ready}, 16'h0);
    chk("rst_out", {busy, rsp1_valid, rsp0_valid, rsp_s, ops_done}, 16'h0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  // Entered in IDLE with the relevant valid(s) already driven; leaves in IDLE at posedge+1.
  task automatic serve(input int id, input logic [6:0] exp_s, input int hold);
    #1;
    chk("grant", {req1_ready, req0_ready}, (id == 0) ? 16'h1 : 16'h2);
    chk("idle_busy", busy, 16'h0);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk("exec", {busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 16'h10);
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      if (id == 0) rsp1_ready = ~i[0]; else rsp0_ready = ~i[0];
      chk("hold", {busy, rsp1_valid, rsp0_valid, rsp_s}, {1'b1, id == 1, id == 0, exp_s});
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("resp", {busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_s},
        {1'b1, 2'b00, id == 1, id == 0, exp_s});
    if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_cnt++;
    chk("done", {busy, rsp1_valid, rsp0_valid, ops_done}, {9'h0, 1'b0, 2'b00, exp_cnt});
    chk("rsp_hold", rsp_s, exp_s);
  endtask

  task automatic run_op(input int id, input logic [5:0] x, input logic [5:0] y,
                        input logic [6:0] exp_s, input int hold);
    if (id == 0) begin
      req0_valid = 1'b1; req0_x = x; req0_y = y;
    end else begin
      req1_valid = 1'b1; req1_x = x; req1_y = y;
    end
    serve(id, exp_s, hold);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    apply_reset();
    run_op(0, 6'd63, 6'd63, 7'd126, 0);

    // Tie: requester 0 first after reset, then strict alternation.
    apply_reset();
    req0_x = 6'd5;  req0_y = 6'd7;
    req1_x = 6'd20; req1_y = 6'd30;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(0, 7'd12, 0);
    serve(1, 7'd50, 0);
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      if (k % 2 == 0) serve(0, 7'd12, 0); else serve(1, 7'd50, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure with the other requester's ready toggling.
    run_op(1, 6'd1, 6'd2, 7'd3, 10);

    // Counter wrap at 4 bits: 15, 0, 1 after completions 15..17.
    apply_reset();
    for (int k = 0; k < 17; k++) run_op(0, 6'(k), 6'd1, 7'(k + 1), 0);
    chk("wrap_final", ops_done, 16'h1);

    // Reset during EXEC discards the operation.
    apply_reset();
    req0_valid = 1'b1; req0_x = 6'd40; req0_y = 6'd40;
    #1;
    chk("rx_ready", req0_ready, 16'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("rx_exec", busy, 16'h1);
    rst = 1'b1;
    #1;
    chk("rx_abort", {busy, rsp1_valid, rsp0_valid, rsp_s, ops_done}, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rx_quiet", {busy, rsp1_valid, rsp0_valid, ops_done}, 16'h0);
    rst = 1'b0;
    exp_cnt = '0;
    run_op(0, 6'd10, 6'd10, 7'd20, 0);

    // Exhaustive operand sweep through requester 0.
    for (int unsigned x = 0; x < 64; x++)
      for (int unsigned y = 0; y < 64; y++)
        run_op(0, 6'(x), 6'(y), 7'(x + y), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
